// File: rtl/fadr_unit.sv
// fadr_unit: FSR-based file-address generator (direct/indirect, FSR auto-modify, valid/ready output stage).
// Optional bounds flag via FADR_BOUND_CHECK_EN. Rev 1.0
`default_nettype none

module fadr_unit #(
   parameter int DIRECT_W   = 5,
   parameter int ADDR_W     = 7,
   parameter int FSR_W      = 8,
   parameter int FILE_DEPTH = 80
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [DIRECT_W-1:0] req_inst,
   input  logic [1:0]          req_mode,
   input  logic                fsr_we,
   input  logic [FSR_W-1:0]    fsr_wdata,
   output logic [FSR_W-1:0]    fsr_q,
   output logic                fa_valid,
   input  logic                fa_ready,
   output logic [ADDR_W-1:0]   fa_addr,
   output logic                fa_ind,
   output logic                fa_null,
   output logic                fa_oob
);

   localparam logic [0:0] S_EMPTY = 1'b0;
   localparam logic [0:0] S_FULL  = 1'b1;

   localparam logic [1:0] MODE_PLAIN    = 2'b00;
   localparam logic [1:0] MODE_POST_INC = 2'b01;
   localparam logic [1:0] MODE_POST_DEC = 2'b10;
   localparam logic [1:0] MODE_PRE_INC  = 2'b11;

   localparam logic [FSR_W-1:0]  C_FSR_ONE  = {{(FSR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] C_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   if ((ADDR_W < DIRECT_W) || (FSR_W < ADDR_W) || (FILE_DEPTH < 1)) begin : g_param_err
      $error("fadr_unit: illegal parameter combination");
   end

   logic [0:0]          r_state;
   logic [FSR_W-1:0]    r_fsr;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_ind;
   logic                r_null;

   logic                w_accept;
   logic                w_indirect;
   logic [ADDR_W-1:0]   w_dir_addr;
   logic [ADDR_W-1:0]   w_ind_addr;
   logic [ADDR_W-1:0]   w_addr_next;
   logic [FSR_W-1:0]    w_fsr_next;

   assign fa_valid   = (r_state == S_FULL);
   assign req_ready  = !fa_valid || fa_ready;
   assign w_accept   = req_valid && req_ready;
   assign w_indirect = (req_inst == '0);

   // Direct addressing keeps the FSR bank bits above the instruction field.
   if (ADDR_W > DIRECT_W) begin : g_bank
      assign w_dir_addr = {r_fsr[ADDR_W-1:DIRECT_W], req_inst};
   end else begin : g_nobank
      assign w_dir_addr = req_inst;
   end

   // Truncated pre-increment equals the low bits of the full-width increment.
   assign w_ind_addr  = (req_mode == MODE_PRE_INC) ? (r_fsr[ADDR_W-1:0] + C_ADDR_ONE)
                                                   : r_fsr[ADDR_W-1:0];
   assign w_addr_next = w_indirect ? w_ind_addr : w_dir_addr;

   always_comb begin
      w_fsr_next = r_fsr;
      if (fsr_we) begin
         w_fsr_next = fsr_wdata;
      end else if (w_accept && w_indirect) begin
         case (req_mode)
            MODE_POST_INC, MODE_PRE_INC: w_fsr_next = r_fsr + C_FSR_ONE;
            MODE_POST_DEC:               w_fsr_next = r_fsr - C_FSR_ONE;
            MODE_PLAIN:                  w_fsr_next = r_fsr;
            default:                     w_fsr_next = r_fsr;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_EMPTY;
         r_fsr   <= '0;
         r_addr  <= '0;
         r_ind   <= 1'b0;
         r_null  <= 1'b0;
      end else begin
         r_fsr <= w_fsr_next;
         if (w_accept) begin
            r_state <= S_FULL;
            r_addr  <= w_addr_next;
            r_ind   <= w_indirect;
            r_null  <= w_indirect && (w_addr_next == '0);
         end else if (fa_ready) begin
            r_state <= S_EMPTY;
         end
      end
   end

`ifdef FADR_BOUND_CHECK_EN
   logic r_oob;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_oob <= 1'b0;
      end else if (w_accept) begin
         r_oob <= (32'(w_addr_next) >= 32'(FILE_DEPTH));
      end
   end

   assign fa_oob = r_oob;
`else
   assign fa_oob = 1'b0;
`endif

   assign fsr_q   = r_fsr;
   assign fa_addr = r_addr;
   assign fa_ind  = r_ind;
   assign fa_null = r_null;

endmodule

`default_nettype wire
